// File: rtl/bcp_eng_sched.sv
// Round-robin dispatch of buffered nodes to NUM_ENG BCP engines, with conflict stop and end-of-solve halt.
// Define SCHED_STATS_EN to add saturating issue/stall counters (stat_issued, stat_stall).
module bcp_eng_sched #(
    parameter int NUM_ENG    = 4,
    parameter int NODE_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NODE_W-1:0]  node_in,
    input  logic               node_in_valid,
    input  logic               node_in_last,
    output logic               node_in_ready,
    output logic [NODE_W-1:0]  eng_node,
    output logic [NUM_ENG-1:0] eng_valid,
    input  logic [NUM_ENG-1:0] eng_ready,
    input  logic [NUM_ENG-1:0] eng_done,
    input  logic [NUM_ENG-1:0] eng_conflict,
    output logic               change_eng,
    output logic               conflict,
    output logic               halt,
    input  logic               clear
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]        stat_issued,
    output logic [31:0]        stat_stall
`endif
);
    localparam int EW = $clog2(NUM_ENG);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_CONFLICT, S_DONE} state_t;
    state_t state, state_n;

    logic [NODE_W-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               full, empty;
    logic [NUM_ENG-1:0] busy;
    logic [NUM_ENG-1:0] issue_oh;
    logic [EW-1:0]      rr_ptr, last_eng, sel;
    logic               have_last, found, conflict_hit, flush, accept, push, issue, dispatching;

    assign full          = (count == CW'(FIFO_DEPTH));
    assign empty         = (count == '0);
    assign dispatching   = (state == S_RUN) || (state == S_DRAIN);
    assign node_in_ready = !full && ((state == S_IDLE) || (state == S_RUN));
    assign accept        = node_in_valid && node_in_ready;
    assign conflict_hit  = (|eng_conflict) && (state != S_DONE);
    // Anything that empties the queue also blocks the push and issue of the same cycle.
    assign flush         = clear || conflict_hit || (state == S_CONFLICT);
    assign push          = accept && !flush;

    // First ready, idle engine at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = rr_ptr;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (!found && eng_ready[rr_ptr + EW'(i)] && !busy[rr_ptr + EW'(i)]) begin
                found = 1'b1;
                sel   = rr_ptr + EW'(i);
            end
        end
    end

    assign issue     = dispatching && !empty && found && !flush;
    assign issue_oh  = issue ? (NUM_ENG'(1) << sel) : '0;
    assign eng_valid = issue_oh;
    assign eng_node  = issue ? mem[rd_ptr] : '0;
    assign conflict  = (state == S_CONFLICT);
    assign halt      = (state == S_DONE);

    always_comb begin
        state_n = state;
        if (clear) begin
            state_n = S_IDLE;
        end else if (conflict_hit) begin
            state_n = S_CONFLICT;
        end else begin
            case (state)
                S_IDLE:  if (accept) state_n = node_in_last ? S_DRAIN : S_RUN;
                S_RUN:   if (accept && node_in_last) state_n = S_DRAIN;
                S_DRAIN: if (empty && (busy == '0)) state_n = S_DONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= node_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            busy       <= '0;
            rr_ptr     <= '0;
            last_eng   <= '0;
            have_last  <= 1'b0;
            change_eng <= 1'b0;
        end else begin
            state <= state_n;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)  wr_ptr <= wr_ptr + PW'(1);
                if (issue) rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(issue);
            end
            if (clear) begin
                busy       <= '0;
                rr_ptr     <= '0;
                last_eng   <= '0;
                have_last  <= 1'b0;
                change_eng <= 1'b0;
            end else begin
                // A done and a new issue to the same engine leave it busy.
                busy       <= (busy & ~eng_done) | issue_oh;
                change_eng <= issue && have_last && (sel != last_eng);
                if (issue) begin
                    rr_ptr    <= sel + EW'(1);
                    last_eng  <= sel;
                    have_last <= 1'b1;
                end
            end
        end
    end

`ifdef SCHED_STATS_EN
    logic stall;
    assign stall = dispatching && !empty && !found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else if (clear) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue && (stat_issued != '1)) stat_issued <= stat_issued + 32'd1;
            if (stall && (stat_stall != '1))  stat_stall  <= stat_stall + 32'd1;
        end
    end
`endif
endmodule
